// File: rtl/carry_lookahead_adder_pkg.sv
// Shared constants and parameter sanity helper for the two-level carry-look-ahead adder.
// The look-ahead cell is a fixed 4-bit design; wider adders tile it.
package carry_lookahead_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_BLOCK = 4;
    localparam int unsigned CLA_CELL_BITS = 4;

    // True when the operand width tiles exactly into fixed-size look-ahead cells.
    function automatic bit width_ok(input int unsigned width, input int unsigned block);
        return (width > 0) && (block == CLA_CELL_BITS) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_cla_block4.sv
// Combinational 4-bit carry-look-ahead cell: sum bits plus block propagate/generate.
// All internal carries are flattened sum-of-products of cin and the bit-level p/g terms.
module cla_block4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);

    logic [3:0] pb;
    logic [3:0] gb;
    logic [3:0] c;

    assign pb = a ^ b;
    assign gb = a & b;

    assign c[0] = cin;
    assign c[1] = gb[0] | (pb[0] & cin);
    assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
    assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & cin);

    assign sum = pb ^ c;

    // Block P/G are kept independent of cin so the upper look-ahead level has no loop through the cells.
    assign p = &pb;
    assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered two-level carry-look-ahead adder: 4-bit CLA cells plus an inter-block
// look-ahead unit, with one cycle of latency from in_valid to out_valid.
module carry_lookahead_adder
    import carry_lookahead_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned BLOCK = DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Pg,
    output logic             Gg
);

    localparam int unsigned NB = WIDTH / BLOCK;

    if (!width_ok(WIDTH, BLOCK)) begin : g_bad_params
        $error("carry_lookahead_adder: WIDTH must be a positive multiple of BLOCK and BLOCK must be 4");
    end

    logic [NB-1:0]    blk_p;
    logic [NB-1:0]    blk_g;
    logic [NB:0]      blk_c;
    logic [WIDTH-1:0] sum_c;
    logic             pg_c;
    logic             gg_c;

    // Carry into block k as a flat sum of products:
    // OR over j<k of (G[j] & P[j+1..k-1]), plus (P[0..k-1] & cin).
    function automatic logic carry_into(input logic [NB-1:0] p,
                                        input logic [NB-1:0] g,
                                        input logic          cin,
                                        input int unsigned   k);
        logic acc;
        logic run;
        acc = 1'b0;
        run = 1'b1;
        for (int j = int'(k) - 1; j >= 0; j--) begin
            acc = acc | (run & g[j]);
            run = run & p[j];
        end
        return acc | (run & cin);
    endfunction

    for (genvar k = 0; k < NB; k++) begin : g_blk
        cla_block4 u_cla (
            .a   (A[k*BLOCK +: BLOCK]),
            .b   (B[k*BLOCK +: BLOCK]),
            .cin (blk_c[k]),
            .sum (sum_c[k*BLOCK +: BLOCK]),
            .p   (blk_p[k]),
            .g   (blk_g[k])
        );
    end

    for (genvar k = 0; k <= NB; k++) begin : g_carry
        assign blk_c[k] = carry_into(blk_p, blk_g, Cin, k);
    end

    assign pg_c = &blk_p;
    assign gg_c = carry_into(blk_p, blk_g, 1'b0, NB);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: datapath registers are reset too, since Sum/Cout/Pg/Gg must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Pg        <= 1'b0;
            Gg        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= sum_c;
                Cout <= blk_c[NB];
                Pg   <= pg_c;
                Gg   <= gg_c;
            end
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench: a 4-bit and a 16-bit adder instance checked against a plain
// arithmetic model (A+B+Cin) with directed corner cases and randomized stimulus.
module tb_carry_lookahead_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v4, c4, ov4, co4, pg4, gg4;
    logic [3:0]  a4, b4, s4;
    logic        v16, c16, ov16, co16, pg16, gg16;
    logic [15:0] a16, b16, s16;

    carry_lookahead_adder #(.WIDTH(4), .BLOCK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .A(a4), .B(b4), .Cin(c4),
        .out_valid(ov4), .Sum(s4), .Cout(co4), .Pg(pg4), .Gg(gg4)
    );

    carry_lookahead_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .A(a16), .B(b16), .Cin(c16),
        .out_valid(ov16), .Sum(s16), .Cout(co16), .Pg(pg16), .Gg(gg16)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what each DUT's registered outputs should read.
    logic        e4_v, e4_co, e4_pg, e4_gg;
    logic [3:0]  e4_s;
    logic        e16_v, e16_co, e16_pg, e16_gg;
    logic [15:0] e16_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e4_v = 1'b0;  e4_s = '0;  e4_co = 1'b0;  e4_pg = 1'b0;  e4_gg = 1'b0;
        e16_v = 1'b0; e16_s = '0; e16_co = 1'b0; e16_pg = 1'b0; e16_gg = 1'b0;
    endtask

    task automatic model_update();
        logic [4:0]  t5;
        logic [16:0] t17;
        e4_v = v4;
        if (v4) begin
            t5 = 5'(a4) + 5'(b4) + 5'(c4);
            e4_s = t5[3:0];  e4_co = t5[4];
            t5 = 5'(a4) + 5'(b4);
            e4_gg = t5[4];
            e4_pg = &(a4 ^ b4);
        end
        e16_v = v16;
        if (v16) begin
            t17 = 17'(a16) + 17'(b16) + 17'(c16);
            e16_s = t17[15:0]; e16_co = t17[16];
            t17 = 17'(a16) + 17'(b16);
            e16_gg = t17[16];
            e16_pg = &(a16 ^ b16);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " v4"},    32'(ov4),  32'(e4_v));
        check({ph, " sum4"},  32'(s4),   32'(e4_s));
        check({ph, " cout4"}, 32'(co4),  32'(e4_co));
        check({ph, " pg4"},   32'(pg4),  32'(e4_pg));
        check({ph, " gg4"},   32'(gg4),  32'(e4_gg));
        check({ph, " v16"},   32'(ov16), 32'(e16_v));
        check({ph, " sum16"}, 32'(s16),  32'(e16_s));
        check({ph, " cout16"},32'(co16), 32'(e16_co));
        check({ph, " pg16"},  32'(pg16), 32'(e16_pg));
        check({ph, " gg16"},  32'(gg16), 32'(e16_gg));
    endtask

    // Inputs are set just after a rising edge; the result is checked 1 time unit after the next one.
    task automatic tick(input string ph);
        @(posedge clk);
        #1;
        model_update();
        check_all(ph);
    endtask

    task automatic mid_cycle_reset(input string ph);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
    } vec4_t;

    vec4_t dir4 [5];

    initial begin
        dir4[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        dir4[1] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
        dir4[2] = '{4'h8, 4'h4, 1'b1, 4'hD, 1'b0};
        dir4[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        dir4[4] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};

        rst_n = 1'b0;
        v4 = 1'b0;  a4 = '0;  b4 = '0;  c4 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
        #1;
        model_reset();
        check_all("por");
        #2 rst_n = 1'b1;

        // Back-to-back directed vectors: each result one cycle after its input.
        for (int i = 0; i < 5; i++) begin
            v4 = 1'b1; a4 = dir4[i].a; b4 = dir4[i].b; c4 = dir4[i].cin;
            tick("dir");
            check("dir sum4 const",  32'(s4),  32'(dir4[i].sum));
            check("dir cout4 const", 32'(co4), 32'(dir4[i].cout));
        end
        check("A5 pg4 const", 32'(pg4), 32'd1);
        check("A5 gg4 const", 32'(gg4), 32'd0);

        // in_valid low with changing operands: out_valid falls, results hold.
        for (int i = 0; i < 2; i++) begin
            v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            tick("hold");
            check("hold sum4 const", 32'(s4), 32'h0);
        end

        // 16-bit carry crossing every block, then the all-ones maximum.
        v16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0;
        tick("c16");
        check("ripple16 sum const",  32'(s16),  32'h0000);
        check("ripple16 cout const", 32'(co16), 32'd1);
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
        tick("max16");
        check("max16 sum const", 32'(s16), 32'hFFFF);

        // Asynchronous reset in the middle of a cycle with results held.
        mid_cycle_reset("rst1");
        v4 = 1'b0; v16 = 1'b0;
        tick("post rst idle");
        v4 = 1'b1; a4 = 4'h7; b4 = 4'h9; c4 = 1'b0;
        v16 = 1'b1; a16 = 16'h1234; b16 = 16'h8765; c16 = 1'b1;
        tick("post rst valid");

        // Randomized regression, including occasional idle cycles and one more mid-stream reset.
        for (int i = 0; i < 10000; i++) begin
            v4  = ($urandom_range(9) != 0);
            a4  = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            v16 = ($urandom_range(9) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            tick("rand");
            if (i == 5000) mid_cycle_reset("rst2");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/carry_lookahead_adder.md
Name: carry_lookahead_adder

Overview:
- Parameterised carry-look-ahead adder. Computes Sum = A + B + Cin, plus carry-out and group propagate/generate.
- Operands are captured and the result is registered, so the result appears one clock after a valid input.
- Used as a low-latency arithmetic leaf in datapaths. Group P/G outputs allow higher-level look-ahead chaining.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be a positive multiple of BLOCK.
- BLOCK, 4, bits per look-ahead group (fixed 4-bit CLA cell).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B/Cin are valid this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in.
- out_valid  output  1  Sum/Cout/Pg/Gg hold a fresh result.
- Sum  output  WIDTH  (A+B+Cin) mod 2^WIDTH.
- Cout  output  1  bit WIDTH of A+B+Cin.
- Pg  output  1  group propagate: AND of all (A[i]^B[i]).
- Gg  output  1  group generate: carry-out assuming Cin=0.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, Sum, Cout, Pg and Gg all go to 0 immediately, regardless of clk.
- Reset stays effective until the first rising edge after deassertion.
- Bit-level terms: p[i] = A[i]^B[i], g[i] = A[i]&B[i].
- Carries inside each BLOCK: c[i+1] = g[i] | p[i]&c[i], fully expanded (no ripple within a block).
- Sum[i] = p[i] ^ c[i].
- Block-level P/G feed a second look-ahead level across blocks:
  - Block carry-ins are computed from Cin and the block P/G, not rippled.
  - For WIDTH=BLOCK this level collapses to a single block.
- Latency is 1 cycle. On a rising edge with in_valid=1:
  - Sum, Cout, Pg and Gg register the combinational result of the current inputs.
  - out_valid is set to 1.
- On a rising edge with in_valid=0: out_valid clears to 0; Sum/Cout/Pg/Gg hold their previous values.
- Back-to-back valid inputs produce back-to-back results, one per cycle. There is no backpressure and no stall.
- Arithmetic is unsigned. Overflow shows only through Cout, with Sum wrapping modulo 2^WIDTH.
- Max case: A=B=all-ones, Cin=1 gives Sum=all-ones, Cout=1.
- Reset asserted mid-stream discards any in-flight result. out_valid is 0 on the cycle after reset releases unless in_valid is high at that edge.
- X/Z on inputs while in_valid=0 must not affect registered outputs.

Decomposition:
- Shared package: default WIDTH/BLOCK constants and an elaboration-time check that WIDTH % BLOCK == 0.
- One natural sub-module, cla_block4:
  - Combinational 4-bit look-ahead cell.
  - Inputs: a, b, cin. Outputs: sum[3:0], block P, block G.
  - Instantiated WIDTH/BLOCK times.
- Top level contains the inter-block look-ahead unit and the output registers.

Test Plan (WIDTH=4, each result checked one cycle after the input edge):
- Reset: assert rst_n=0 mid-cycle -> out_valid=0, Sum=0000, Cout=0 immediately, without waiting for a clock edge.
- A=0000, B=0000, Cin=0, in_valid=1 -> Sum=0000, Cout=0, Pg=0, Gg=0, out_valid=1.
- A=0011, B=0101, Cin=0 -> Sum=1000, Cout=0. Also A=1000, B=0100, Cin=1 -> Sum=1101, Cout=0.
- A=1111, B=1111, Cin=1 -> Sum=1111, Cout=1, Gg=1. Also A=1010, B=0101, Cin=1 -> Sum=0000, Cout=1, Pg=1, Gg=0.
- Pipeline and hold: three consecutive valid vectors, then in_valid=0.
  - Each result appears exactly 1 cycle after its input.
  - After in_valid drops, out_valid falls and Sum holds its last value.
- WIDTH=16 regression: exhaustive random 10k vectors compared against A+B+Cin, plus A=FFFF, B=0001, Cin=0 -> Sum=0000, Cout=1 (carry crossing every block).
